// File: rtl/regression_sum_accumulator.sv
// regression_sum_accumulator
//   Sweeps the sample loader index cnt over 0..N_SAMPLES-1 after a start
//   pulse and accumulates the four least-squares sums (Σx, Σy, Σxy, Σx²)
//   at full precision. Sums are held with done=1 until the next start.
//
// Parameters
//   N_SAMPLES : samples per sweep, 1..256
// Ports
//   clk, rst         : rising-edge clock, async active-low reset
//   start            : one-cycle sweep request (honoured in IDLE/DONE only)
//   x, y             : Q10.10 samples from the loader for the current cnt
//   cnt              : sample index to the loader
//   busy, done       : sweep in progress / sums valid
//   sum_x, sum_y     : Q18.10 sums
//   sum_xy, sum_xx   : Q28.20 sums
// Build option
//   REG_INPUT_EN : register x/y before the datapath; adds a DRAIN state and
//                  one cycle of latency.
module regression_sum_accumulator #(
  parameter int N_SAMPLES = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] x,
  input  logic [19:0] y,
  output logic [7:0]  cnt,
  output logic        busy,
  output logic        done,
  output logic [27:0] sum_x,
  output logic [27:0] sum_y,
  output logic [47:0] sum_xy,
  output logic [47:0] sum_xx
);

  localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

`ifdef REG_INPUT_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t      state, state_n;
  logic        clr, acc_en;
  logic [19:0] xs, ys;
  logic [39:0] p_xy, p_xx;

  // A start is accepted only when no sweep is running.
  assign clr = start && (state == IDLE || state == DONE);

`ifdef REG_INPUT_EN
  // s_vld marks that xs/ys hold a sample answered by a LOAD-cycle cnt; it is
  // low in the first LOAD cycle and high in DRAIN for the final sample.
  logic s_vld;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xs    <= '0;
      ys    <= '0;
      s_vld <= 1'b0;
    end else begin
      xs    <= x;
      ys    <= y;
      s_vld <= (state == LOAD);
    end
  end
  assign acc_en = s_vld && (state == LOAD || state == DRAIN);
  assign busy   = (state == LOAD) || (state == DRAIN);
`else
  assign xs     = x;
  assign ys     = y;
  assign acc_en = (state == LOAD);
  assign busy   = (state == LOAD);
`endif

  assign done = (state == DONE);
  assign p_xy = 40'(xs) * 40'(ys);
  assign p_xx = 40'(xs) * 40'(xs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = LOAD;
      LOAD: if (cnt >= LAST) begin
`ifdef REG_INPUT_EN
        state_n = DRAIN;
`else
        state_n = DONE;
`endif
      end
`ifdef REG_INPUT_EN
      DRAIN: state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Index: held at LAST once the sweep reaches the final sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             cnt <= '0;
    else if (clr)                         cnt <= '0;
    else if (state == LOAD && cnt < LAST) cnt <= cnt + 8'd1;
  end

  // Widths leave headroom for 256 full-scale samples, so no wrap is possible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_xy <= '0;
      sum_xx <= '0;
    end else if (clr) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_xy <= '0;
      sum_xx <= '0;
    end else if (acc_en) begin
      sum_x  <= sum_x  + 28'(xs);
      sum_y  <= sum_y  + 28'(ys);
      sum_xy <= sum_xy + 48'(p_xy);
      sum_xx <= sum_xx + 48'(p_xx);
    end
  end

endmodule
